// File: rtl/rv32i_types.sv
// Shared types and constants for the cache datapath and its downstream (DFP) memory port.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    COOL
  } dfp_resp_state_t;

  typedef logic [255:0] cache_line_t;

  localparam int LINE_BYTES       = 32;
  localparam int LINE_OFFSET_BITS = $clog2(LINE_BYTES);

endpackage

// File: rtl/dfp_line_array.sv
// Line store behind the DFP responder: synchronous reset-to-zero, one write port,
// one combinational read port.
module dfp_line_array
  import rv32i_types::*;
#(
  parameter int DEPTH_LINES = 64,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  cache_line_t      wdata_i,
  input  logic [IDX_W-1:0] ridx_i,
  output cache_line_t      rdata_o
);

  cache_line_t mem_q [DEPTH_LINES];

  // Reset has priority, so a commit on the same edge as rst is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH_LINES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/dfp_line_responder.sv
// Fixed-latency DFP memory responder with a sticky checker for the cache-side
// request protocol (request held stable until dfp_resp, dropped the cycle after).
module dfp_line_responder
  import rv32i_types::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   dfp_addr,
  input  logic          dfp_read,
  input  logic          dfp_write,
  input  logic [255:0]  dfp_wdata,
  output logic [255:0]  dfp_rdata,
  output logic          dfp_resp,
  output logic          proto_err
);

  localparam int         IDX_W  = $clog2(DEPTH_LINES);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dfp_resp_state_t state_q;
  logic [3:0]      cnt_q;
  logic [31:0]     addr_q;
  logic            rd_q;
  logic            wr_q;
  cache_line_t     wdata_q;
  cache_line_t     rdata_q;
  logic            resp_q;
  logic            err_q;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  cache_line_t      rd_line;
  logic             commit;
  logic             req_any;
  logic             req_changed;

  // With LATENCY=1 the read happens on the accepting edge, before addr_q is loaded.
  always_comb begin
    rd_idx = addr_q[LINE_OFFSET_BITS +: IDX_W];
    if (state_q == IDLE) begin
      rd_idx = dfp_addr[LINE_OFFSET_BITS +: IDX_W];
    end
  end

  assign wr_idx  = addr_q[LINE_OFFSET_BITS +: IDX_W];
  assign commit  = (state_q == RESP) && wr_q;
  assign req_any = dfp_read || dfp_write;

  // wdata only has to be held for writes; a read's wdata is don't-care.
  assign req_changed = (dfp_read != rd_q) || (dfp_write != wr_q) ||
                       (dfp_addr != addr_q) || (wr_q && (dfp_wdata != wdata_q));

  dfp_line_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (commit),
    .widx_i  (wr_idx),
    .wdata_i (wdata_q),
    .ridx_i  (rd_idx),
    .rdata_o (rd_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      resp_q  <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            addr_q  <= dfp_addr;
            rd_q    <= dfp_read;
            wr_q    <= dfp_write;
            wdata_q <= dfp_wdata;
            cnt_q   <= LAT_M1;
            if ((dfp_read && dfp_write) || (dfp_addr[LINE_OFFSET_BITS-1:0] != '0)) begin
              err_q <= 1'b1;
            end
            if (LATENCY == 1) begin
              state_q <= RESP;
              resp_q  <= 1'b1;
              if (!dfp_write) begin
                rdata_q <= rd_line;
              end
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (req_changed) begin
            err_q <= 1'b1;
          end
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            if (!wr_q) begin
              rdata_q <= rd_line;
            end
          end
        end
        RESP: begin
          if (req_changed) begin
            err_q <= 1'b1;
          end
          state_q <= COOL;
        end
        COOL: begin
          if (req_any) begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dfp_resp  = resp_q;
  assign dfp_rdata = rdata_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_dfp_line_responder.sv
// Bench for dfp_line_responder: LATENCY=4 instance under a queue scoreboard with a
// line-memory reference model, plus a LATENCY=1 instance driven directly.
module tb_dfp_line_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 64;
  localparam int PER   = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #(PER/2) clk = ~clk;

  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic         proto_err;

  logic         rst1;
  logic [31:0]  addr1;
  logic         rd1;
  logic         wr1;
  logic [255:0] wd1;
  logic [255:0] rdata1;
  logic         resp1;
  logic         err1;

  dfp_line_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .dfp_addr  (dfp_addr),
    .dfp_read  (dfp_read),
    .dfp_write (dfp_write),
    .dfp_wdata (dfp_wdata),
    .dfp_rdata (dfp_rdata),
    .dfp_resp  (dfp_resp),
    .proto_err (proto_err)
  );

  dfp_line_responder #(.LATENCY(1), .DEPTH_LINES(DEPTH)) u_dut_l1 (
    .clk       (clk),
    .rst       (rst1),
    .dfp_addr  (addr1),
    .dfp_read  (rd1),
    .dfp_write (wr1),
    .dfp_wdata (wd1),
    .dfp_rdata (rdata1),
    .dfp_resp  (resp1),
    .proto_err (err1)
  );

  // ---------------- scoreboard state and reference model ----------------
  int checks   = 0;
  int failures = 0;
  int resp_seen = 0;

  logic [255:0] exp_q[$];
  longint       exp_t_q[$];
  bit           exp_wr_q[$];

  logic [255:0] model_mem [DEPTH];
  bit           model_err;

  logic [255:0] mon_e;
  longint       mon_t;
  bit           mon_w;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] a);
    return int'((a / 32) % DEPTH);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_err = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (dfp_resp) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=1 required=0 t=%0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        mon_w = exp_wr_q.pop_front();
        check("resp_time", 256'($time), 256'(mon_t));
        if (!mon_w) check("read_data", dfp_rdata, mon_e);
      end
    end else begin
      check("rdata_zero_when_idle", dfp_rdata, '0);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_reset();
    rst = 1'b1;
    dfp_read = 1'b0;
    dfp_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] data);
    bit got;
    longint t;
    dfp_read  = rd;
    dfp_write = wr;
    dfp_addr  = addr;
    dfp_wdata = data;
    @(posedge clk);
    t = $time;
    exp_t_q.push_back(t + (LAT - 1) * PER + PER / 2);
    if (wr) begin
      exp_wr_q.push_back(1'b1);
      exp_q.push_back('0);
      model_mem[midx(addr)] = data;
    end else begin
      exp_wr_q.push_back(1'b0);
      exp_q.push_back(model_mem[midx(addr)]);
    end
    if ((rd && wr) || (addr[4:0] != 5'd0)) model_err = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (dfp_resp) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout actual=none required=dfp_resp addr=%h", addr);
    end
    @(negedge clk);
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [255:0] line_x;
  logic [31:0]  ra;
  int           seen_before;

  initial begin
    rst = 1'b1;  dfp_read = 1'b0; dfp_write = 1'b0; dfp_addr = '0; dfp_wdata = '0;
    rst1 = 1'b1; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_resp", 256'(dfp_resp), '0);
    check("reset_rdata", dfp_rdata, '0);
    check("reset_err", 256'(proto_err), '0);
    check("reset_l1_resp", 256'(resp1), '0);
    rst = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Read of a fresh line, then write/read-back, then aliasing.
    do_req(1'b1, 1'b0, 32'h0000_0080, rand_line());
    do_req(1'b0, 1'b1, 32'h0000_0040, {8{32'h1111_1111}});
    do_req(1'b1, 1'b0, 32'h0000_0040, '0);
    check("err_after_clean_rw", 256'(proto_err), 256'(model_err));
    do_req(1'b0, 1'b1, 32'h0000_0020, {8{32'hAAAA_AAAA}});
    do_req(1'b0, 1'b1, 32'h0000_0820, {8{32'h5555_5555}});
    do_req(1'b1, 1'b0, 32'h0000_0020, '0);

    // Randomized aligned traffic over a small address window (with aliasing upper bits).
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom_range(0, 3), 11'd0, 5'd0, 11'd0} | (32'($urandom_range(0, 15)) << 5);
      if ($urandom_range(0, 1) == 1) do_req(1'b0, 1'b1, ra, rand_line());
      else                           do_req(1'b1, 1'b0, ra, rand_line());
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check("err_after_random", 256'(proto_err), 256'(model_err));

    // Simultaneous read+write is a write and sets the sticky flag; misaligned read too.
    line_x = rand_line();
    do_req(1'b1, 1'b1, 32'h0000_0060, line_x);
    check("err_after_rw_both", 256'(proto_err), 256'(model_err));
    do_req(1'b1, 1'b0, 32'h0000_0060, '0);
    do_req(1'b1, 1'b0, 32'h0000_0044, '0);
    check("err_sticky", 256'(proto_err), 256'(model_err));
    do_reset();
    check("err_cleared_by_rst", 256'(proto_err), 256'(model_err));
    do_req(1'b1, 1'b0, 32'h0000_0060, '0);

    // Reset while the write is waiting: no response and no commit.
    seen_before = resp_seen;
    dfp_write = 1'b1; dfp_addr = 32'h0000_00A0; dfp_wdata = rand_line();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    dfp_write = 1'b0;
    model_clear();
    check("resp_after_abort", 256'(dfp_resp), '0);
    repeat (LAT + 3) @(negedge clk);
    check("no_resp_after_abort", 256'(resp_seen), 256'(seen_before));
    do_req(1'b1, 1'b0, 32'h0000_00A0, '0);
    check("err_after_abort", 256'(proto_err), 256'(model_err));

    // LATENCY=1 instance: write, then a read held high through COOL.
    line_x = rand_line();
    wr1 = 1'b1; addr1 = 32'h0000_0100; wd1 = line_x;
    @(posedge clk);
    @(negedge clk);
    check("l1_wr_resp", 256'(resp1), 256'(1));
    @(negedge clk);
    wr1 = 1'b0;
    @(negedge clk);
    check("l1_err_clean", 256'(err1), '0);
    rd1 = 1'b1; addr1 = 32'h0000_0100;
    @(posedge clk);
    @(negedge clk);
    check("l1_rd_resp", 256'(resp1), 256'(1));
    check("l1_rd_data", rdata1, line_x);
    @(negedge clk);
    check("l1_cool_resp", 256'(resp1), '0);
    check("l1_cool_rdata", rdata1, '0);
    @(negedge clk);
    check("l1_no_reaccept", 256'(resp1), '0);
    check("l1_err_cool", 256'(err1), 256'(1));
    rd1 = 1'b0;
    @(negedge clk);
    check("l1_idle_resp", 256'(resp1), '0);

    repeat (2) @(negedge clk);
    check("queue_drained", 256'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(PER * 20000);
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dfp_line_responder.md
# dfp_line_responder

Memory-side responder for the cache's downstream (DFP) port: accepts 256-bit cache-line read and write requests issued by the cache and answers each with a one-cycle `dfp_resp` after a fixed, parameterised latency. It sits below the cache in the testbench and integration top, behind the cache's write-back and allocate paths. It acts as a synthesizable backing store for closed-loop cache verification, and it checks that the cache obeys the request protocol.

## Interface
- `LATENCY`, 4: cycles from request acceptance to `dfp_resp`; legal range 1..15.
- `DEPTH_LINES`, 64: number of 32-byte lines stored; power of two, 2..256.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `dfp_addr` input 32: line address; bits [4:0] are expected to be zero.
- `dfp_read` input 1: read request; held until `dfp_resp`.
- `dfp_write` input 1: write request; held until `dfp_resp`.
- `dfp_wdata` input 256: line write data; held until `dfp_resp`.
- `dfp_rdata` output 256: line read data; valid only while `dfp_resp`=1.
- `dfp_resp` output 1: one-cycle completion pulse.
- `proto_err` output 1: sticky protocol-violation flag.

## Operation
- Line index is `dfp_addr[5 +: log2(DEPTH_LINES)]`. Bits [4:0] are ignored for storage. Upper bits alias.
- The FSM has four states: IDLE, WAIT, RESP, COOL.
  - IDLE: if `dfp_read` or `dfp_write` is high, accept the request. Latch the address, the op and `dfp_wdata`, and load the counter with LATENCY-1. Go to RESP if LATENCY=1, otherwise go to WAIT.
  - WAIT: decrement the counter. At 1 → go to RESP.
  - RESP: assert `dfp_resp`.
    - Read: drive `dfp_rdata` from the array at the latched index.
    - Write: commit the latched wdata to the array on this edge.
    - Then go to COOL.
  - COOL: ignore all request inputs for one cycle, then go to IDLE. The initiator drops its request in the cycle after `dfp_resp`.
- `proto_err` sets, and stays set until `rst`, on any of:
  - `dfp_read` and `dfp_write` both high in IDLE. The request is still accepted, and write takes priority.
  - `dfp_addr[4:0]`≠0 at acceptance.
  - The request drops, or `dfp_addr`, op or `dfp_wdata` changes, during WAIT or RESP. The latched values are still used.
  - A request is still asserted in COOL.
- Read-after-write to the same line returns the new data, because the commit happens before the next acceptance.

## Timing
- Reset values:
  - `dfp_resp`=0, `dfp_rdata`=0, `proto_err`=0.
  - State=IDLE, counter=0.
  - All array lines=0.
- Latency: a request is first seen high in IDLE at edge N; `dfp_resp` is high during cycle N+LATENCY.
- `dfp_rdata` is 0 whenever `dfp_resp`=0.
- Minimum spacing between accepted requests is LATENCY+2 cycles.
- `rst` during WAIT, RESP or COOL:
  - Aborts the transaction and returns to IDLE.
  - A pending write is not committed.
  - `dfp_resp` is low in the following cycle.
- `rst` takes precedence over a same-edge write commit.

## Structure
- Add to the shared `rv32i_types` package:
  - typedef `dfp_resp_state_t` enum, with the values IDLE, WAIT, RESP and COOL.
  - typedef `cache_line_t` as `logic [255:0]`.
  - constants `LINE_OFFSET_BITS`=5 and `LINE_BYTES`=32.
- Sub-module `dfp_line_array`: `DEPTH_LINES`×256 register array with synchronous reset-to-zero, a single write port and a combinational read port. The FSM, counter, latches and checker stay in the top module.

## Test plan
- Write 0x1111…1111 to 0x00000040, then read 0x00000040 (LATENCY=4) → each `dfp_resp` arrives 4 cycles after its request edge, the read returns 0x1111…1111, and `proto_err`=0.
- Read 0x00000080 immediately after reset → `dfp_rdata`=0 on `dfp_resp`.
- Write 0xAAAA…AAAA to 0x00000020, then 0x5555…5555 to 0x00000820 (DEPTH_LINES=64) → reading 0x00000020 returns 0x5555…5555, because the two addresses alias.
- Assert `dfp_read` and `dfp_write` together at 0x00000060 → it is treated as a write, and `proto_err`=1 until `rst`.
- Start a write to 0x000000A0 and assert `rst` in WAIT → there is no `dfp_resp`, and a later read of 0x000000A0 returns 0.
- LATENCY=1, with the read held high through COOL → `dfp_resp` comes in the cycle after acceptance, the request is not re-accepted in COOL, and `proto_err`=1.
